// File: rtl/ff_bank.sv
// ff_bank: bank of independent SR/JK/D/T flip-flop channels sharing a mode register, with SR-illegal detection and a saturating error counter
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - synchronous active-low reset
//   mode_in    - mode to load (00 SR, 01 JK, 10 D, 11 T)
//   mode_ld    - load strobe for mode_in
//   en         - per-channel clock enable
//   a, b       - per-channel S/J/D/T and R/K inputs
//   clr_cnt    - synchronous clear of err_cnt and err_sticky
//   q, qbar    - channel state and its complement
//   mode       - active mode register
//   illegal    - per-channel registered SR-illegal flag
//   err_cnt    - saturating count of cycles with any illegal channel
//   err_sticky - set on the first illegal cycle, held until cleared
module ff_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_in,
    input  logic             mode_ld,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] illegal,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
);
    typedef enum logic [1:0] {M_SR = 2'b00, M_JK = 2'b01, M_D = 2'b10, M_T = 2'b11} mode_t;
    mode_t            r_mode;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_ill;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sticky;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_rst;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_ill;
    logic             w_any;
    // Set/reset decode is shared by SR and JK; JK additionally toggles on a=b=1,
    // which SR treats as hold-and-flag.
    always_comb begin
        w_set  = a & ~b;
        w_rst  = ~a & b;
        w_sel  = r_mode == M_SR ? (w_set | (r_q & ~w_rst)) :
                 r_mode == M_JK ? (w_set | (~w_rst & (r_q ^ (a & b)))) :
                 r_mode == M_D  ? a : (r_q ^ a);
        w_next = (en & w_sel) | (~en & r_q);
        w_ill  = r_mode == M_SR ? (en & a & b) : '0;
        w_any  = |w_ill;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode   <= M_SR;
            r_q      <= '0;
            r_ill    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (mode_ld) r_mode <= mode_t'(mode_in);
            r_q   <= w_next;
            r_ill <= w_ill;
            // Clear wins over a coincident event; the event still shows on illegal.
            if (clr_cnt) begin
                r_cnt    <= '0;
                r_sticky <= 1'b0;
            end else if (w_any) begin
                r_sticky <= 1'b1;
                if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
    assign q          = r_q;
    assign qbar       = ~r_q;
    assign mode       = r_mode;
    assign illegal    = r_ill;
    assign err_cnt    = r_cnt;
    assign err_sticky = r_sticky;
endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: directed self-checking bench for ff_bank with WIDTH=4, CNT_W=2
module tb_ff_bank;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode_in;
    logic       mode_ld;
    logic [3:0] en, a, b;
    logic       clr_cnt;
    logic [3:0] q, qbar, illegal;
    logic [1:0] mode;
    logic [1:0] err_cnt;
    logic       err_sticky;
    int n_cmp = 0;
    int n_bad = 0;

    ff_bank #(.WIDTH(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .mode_ld(mode_ld),
        .en(en), .a(a), .b(b), .clr_cnt(clr_cnt),
        .q(q), .qbar(qbar), .mode(mode), .illegal(illegal),
        .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode_ld = 1'b1; mode_in = 2'b11; en = 4'hF; a = 4'hF; b = 4'h0; clr_cnt = 1'b0;
        step();
        step();
        n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL reset_q: got %h want 0", q); end
        n_cmp++; if (qbar !== 4'hF) begin n_bad++; $display("FAIL reset_qbar: got %h want f", qbar); end
        n_cmp++; if (mode !== 2'b00) begin n_bad++; $display("FAIL reset_mode: got %b want 00", mode); end
        n_cmp++; if (illegal !== 4'h0) begin n_bad++; $display("FAIL reset_illegal: got %h want 0", illegal); end
        n_cmp++; if (err_cnt !== 2'd0 || err_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_err: got cnt=%0d sticky=%b want 0/0", err_cnt, err_sticky); end
    endtask

    task automatic test_sr();
        rst_n = 1'b1; mode_ld = 1'b0; mode_in = 2'b00; en = 4'hF;
        a = 4'h0; b = 4'hF; step();
        n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL sr_reset: got %h want 0", q); end
        a = 4'hF; b = 4'h0; step();
        n_cmp++; if (q !== 4'hF) begin n_bad++; $display("FAIL sr_set: got %h want f", q); end
        a = 4'h0; b = 4'h0; step();
        n_cmp++; if (q !== 4'hF || qbar !== 4'h0) begin n_bad++; $display("FAIL sr_hold: got q=%h qbar=%h want f/0", q, qbar); end
        n_cmp++; if (illegal !== 4'h0) begin n_bad++; $display("FAIL sr_hold_ill: got %h want 0", illegal); end
        a = 4'h5; b = 4'hA; step();
        n_cmp++; if (q !== 4'h5) begin n_bad++; $display("FAIL sr_mixed: got %h want 5", q); end
    endtask

    task automatic test_sr_illegal();
        logic [1:0] exp_cnt;
        a = 4'hF; b = 4'hF; step();
        n_cmp++; if (q !== 4'h5) begin n_bad++; $display("FAIL ill_hold: got %h want 5", q); end
        n_cmp++; if (illegal !== 4'hF) begin n_bad++; $display("FAIL ill_flag: got %h want f", illegal); end
        n_cmp++; if (err_cnt !== 2'd1 || err_sticky !== 1'b1) begin n_bad++; $display("FAIL ill_cnt1: got cnt=%0d sticky=%b want 1/1", err_cnt, err_sticky); end
        a = 4'h0; b = 4'h0; step();
        n_cmp++; if (illegal !== 4'h0 || err_cnt !== 2'd1 || err_sticky !== 1'b1) begin n_bad++; $display("FAIL ill_oneshot: got ill=%h cnt=%0d sticky=%b want 0/1/1", illegal, err_cnt, err_sticky); end
        for (int i = 0; i < 4; i++) begin
            a = 4'hF; b = 4'hF; step();
            exp_cnt = (i == 0) ? 2'd2 : 2'd3;
            n_cmp++; if (err_cnt !== exp_cnt) begin n_bad++; $display("FAIL ill_sat%0d: got %0d want %0d", i, err_cnt, exp_cnt); end
        end
        en = 4'h2; step();
        n_cmp++; if (illegal !== 4'h2 || err_cnt !== 2'd3) begin n_bad++; $display("FAIL ill_partial: got ill=%h cnt=%0d want 2/3", illegal, err_cnt); end
        en = 4'hF;
    endtask

    task automatic test_jk_load();
        mode_ld = 1'b1; mode_in = 2'b01; a = 4'hF; b = 4'hF; step();
        n_cmp++; if (mode !== 2'b01) begin n_bad++; $display("FAIL jk_mode: got %b want 01", mode); end
        n_cmp++; if (q !== 4'h5 || illegal !== 4'hF) begin n_bad++; $display("FAIL jk_loadedge: got q=%h ill=%h want 5/f", q, illegal); end
        mode_ld = 1'b0; step();
        n_cmp++; if (q !== 4'hA || illegal !== 4'h0) begin n_bad++; $display("FAIL jk_toggle: got q=%h ill=%h want a/0", q, illegal); end
        a = 4'h3; b = 4'h5; step();
        n_cmp++; if (q !== 4'hB) begin n_bad++; $display("FAIL jk_mixed: got %h want b", q); end
        a = 4'h0; b = 4'h0; clr_cnt = 1'b1; step();
        clr_cnt = 1'b0;
        n_cmp++; if (err_cnt !== 2'd0 || err_sticky !== 1'b0 || q !== 4'hB) begin n_bad++; $display("FAIL jk_clr: got cnt=%0d sticky=%b q=%h want 0/0/b", err_cnt, err_sticky, q); end
    endtask

    task automatic test_d();
        mode_ld = 1'b1; mode_in = 2'b10; step();
        mode_ld = 1'b0;
        a = 4'h6; b = 4'hF; step();
        n_cmp++; if (q !== 4'h6 || illegal !== 4'h0 || mode !== 2'b10) begin n_bad++; $display("FAIL d_load: got q=%h ill=%h mode=%b want 6/0/10", q, illegal, mode); end
        a = 4'h9; en = 4'h3; step();
        n_cmp++; if (q !== 4'h5) begin n_bad++; $display("FAIL d_enable: got %h want 5", q); end
        en = 4'hF;
    endtask

    task automatic test_t();
        a = 4'h0; b = 4'h0; step();
        mode_ld = 1'b1; mode_in = 2'b11; step();
        mode_ld = 1'b0;
        n_cmp++; if (q !== 4'h0 || mode !== 2'b11) begin n_bad++; $display("FAIL t_start: got q=%h mode=%b want 0/11", q, mode); end
        en = 4'h3; a = 4'hF;
        step();
        n_cmp++; if (q !== 4'h3) begin n_bad++; $display("FAIL t_e1: got %h want 3", q); end
        step();
        n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL t_e2: got %h want 0", q); end
        step();
        n_cmp++; if (q !== 4'h3) begin n_bad++; $display("FAIL t_e3: got %h want 3", q); end
    endtask

    task automatic test_reset_override();
        mode_ld = 1'b1; mode_in = 2'b10; en = 4'h0; a = 4'h0; step();
        mode_ld = 1'b0;
        n_cmp++; if (mode !== 2'b10 || q !== 4'h3) begin n_bad++; $display("FAIL rst_pre: got mode=%b q=%h want 10/3", mode, q); end
        rst_n = 1'b0; a = 4'h9; en = 4'hF; clr_cnt = 1'b1; mode_ld = 1'b1; mode_in = 2'b11;
        #2;
        n_cmp++; if (q !== 4'h3 || mode !== 2'b10) begin n_bad++; $display("FAIL rst_noedge: got q=%h mode=%b want 3/10", q, mode); end
        step();
        n_cmp++; if (q !== 4'h0 || qbar !== 4'hF || mode !== 2'b00 || illegal !== 4'h0 || err_cnt !== 2'd0 || err_sticky !== 1'b0) begin
            n_bad++; $display("FAIL rst_override: got q=%h qbar=%h mode=%b ill=%h cnt=%0d sticky=%b", q, qbar, mode, illegal, err_cnt, err_sticky);
        end
        rst_n = 1'b1; clr_cnt = 1'b0; mode_ld = 1'b0; a = 4'h9; b = 4'hF; step();
        n_cmp++; if (q !== 4'h0 || illegal !== 4'h9 || err_cnt !== 2'd1) begin n_bad++; $display("FAIL rst_sr_after: got q=%h ill=%h cnt=%0d want 0/9/1", q, illegal, err_cnt); end
    endtask

    task automatic test_clr_priority();
        a = 4'hF; b = 4'hF; clr_cnt = 1'b1; step();
        n_cmp++; if (illegal !== 4'hF || err_cnt !== 2'd0 || err_sticky !== 1'b0) begin n_bad++; $display("FAIL clr_prio: got ill=%h cnt=%0d sticky=%b want f/0/0", illegal, err_cnt, err_sticky); end
        clr_cnt = 1'b0; step();
        n_cmp++; if (err_cnt !== 2'd1 || err_sticky !== 1'b1) begin n_bad++; $display("FAIL clr_after: got cnt=%0d sticky=%b want 1/1", err_cnt, err_sticky); end
    endtask

    initial begin
        test_reset();
        test_sr();
        test_sr_illegal();
        test_jk_load();
        test_d();
        test_t();
        test_reset_override();
        test_clr_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ff_bank.md
FF_BANK -- requirements
Module: ff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent flip-flop channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the illegal-event counter (2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mode_in  input  2  mode to load: 00 SR, 01 JK, 10 D, 11 T.
REQ-006 SHALL have port mode_ld  input  1  load strobe for mode_in.
REQ-007 SHALL have port en  input  WIDTH  per-channel clock enable.
REQ-008 SHALL have port a  input  WIDTH  per-channel S / J / D / T input, by mode.
REQ-009 SHALL have port b  input  WIDTH  per-channel R / K input; ignored in D and T modes.
REQ-010 SHALL have port clr_cnt  input  1  synchronous clear of err_cnt and err_sticky.
REQ-011 SHALL have port q  output  WIDTH  registered channel state.
REQ-012 SHALL have port qbar  output  WIDTH  bitwise complement of q at all times.
REQ-013 SHALL have port mode  output  2  currently active mode register.
REQ-014 SHALL have port illegal  output  WIDTH  registered per-channel SR-illegal flag.
REQ-015 SHALL have port err_cnt  output  CNT_W  saturating count of illegal cycles.
REQ-016 SHALL have port err_sticky  output  1  set on first illegal cycle, held until cleared.

Function
REQ-017 mode SHALL load mode_in at the edge where mode_ld=1; the new mode SHALL govern channel updates from the following edge (channel updates at the loading edge use the old mode).
REQ-018 A channel with en[i]=0 SHALL hold q[i] regardless of a, b, and mode.
REQ-019 SR mode, en[i]=1: a=1,b=0 -> q=1; a=0,b=1 -> q=0; a=0,b=0 -> hold; a=1,b=1 -> hold and flag illegal.
REQ-020 JK mode, en[i]=1: 10 -> q=1; 01 -> q=0; 00 -> hold; 11 -> q toggles; never illegal.
REQ-021 D mode, en[i]=1: q takes a[i] at each edge.
REQ-022 T mode, en[i]=1: a[i]=1 toggles q[i]; a[i]=0 holds.
REQ-023 illegal[i] SHALL be 1 for exactly the cycle after an edge at which mode=SR, en[i]=1, a[i]=b[i]=1; otherwise 0.
REQ-024 err_cnt SHALL increment by 1 (not by the number of channels) at each edge where any channel meets the REQ-023 condition.
REQ-025 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 err_sticky SHALL set at the same edge err_cnt would increment.
REQ-027 clr_cnt=1 SHALL zero err_cnt and err_sticky at that edge; clr_cnt SHALL take priority over a simultaneous illegal event (the event is not counted), though illegal[] still reports it.
REQ-028 Channels SHALL be fully independent; no channel's inputs affect another's q.
REQ-029 Latency: q, illegal, err_cnt, err_sticky SHALL reflect inputs sampled at edge N immediately after edge N (one register stage, no combinational input-to-output path except qbar from q).

Reset
REQ-030 At an edge where rst_n=0: q=0, qbar=all ones, mode=00 (SR), illegal=0, err_cnt=0, err_sticky=0.
REQ-031 rst_n=0 SHALL override mode_ld, en, clr_cnt, and all data inputs; reset asserted mid-operation SHALL discard any pending toggle or load.
REQ-032 Outputs SHALL change only on clock edges; asserting rst_n without a clock edge SHALL have no effect.

Verification (WIDTH=4, CNT_W=2)
REQ-033 Reset, then en=F, mode SR, a=0,b=F -> q=0; a=F,b=0 -> q=F; a=0,b=0 -> q=F, qbar=0.
REQ-034 SR, q=5, en=F, a=F,b=F -> q stays 5, illegal=F for one cycle, err_cnt=1, err_sticky=1; repeat 4 more cycles -> err_cnt saturates at 3.
REQ-035 Load JK (mode_ld=1, mode_in=01) with a=F,b=F at the same edge -> SR rule applies at that edge (illegal=F); next edge with a=F,b=F -> q toggles 5->A, illegal=0.
REQ-036 T mode, q=0, en=3, a=F for 3 edges -> q=3,0,3; upper channels stay 0.
REQ-037 D mode, a=9, en=F, clr_cnt=1 simultaneous with rst_n=0 -> all outputs at reset values, mode=SR; after release, D needs reload.
REQ-038 SR illegal event coincident with clr_cnt=1 -> illegal=F, err_cnt=0, err_sticky=0.
